// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// This is a generic inter-stage register for the 64-bit RISC-V pipeline. It
// carries one opaque payload of DW bits from an upstream stage to a downstream
// stage. It replaces the fixed-field IF/ID, ID/EX and EX/MEM registers.
//
// A two-entry skid buffer sits between the stages:
//   - main : the entry currently offered downstream. It drives out_data_o.
//   - skid : catches the one payload accepted in the cycle that downstream
//            stalls. This keeps in_ready_o a pure flop output.
//
// Valid/ready handshake, which applies to both sides:
//   - A transfer happens on a rising clock edge where valid and ready are
//     both high.
//   - valid must not depend combinationally on ready.
//   - Once the stage raises out_valid_o, it holds out_valid_o and
//     out_data_o stable until the transfer happens. Flush and reset are the
//     only exceptions.
//   - Upstream data is sampled only on a transfer.
//   - No output of this stage depends combinationally on any input.
//     This means no ready or valid path crosses the stage boundary.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush_i      synchronous flush; drops every held entry
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept (flop)
//   in_data_i    upstream payload [DW-1:0]
//   out_valid_o  payload available downstream (flop)
//   out_ready_i  downstream accepts
//   out_data_o   payload [DW-1:0], the main entry (flop)
//   occupancy_o  entries held: 0, 1 or 2; also the FSM state
//   stall_cnt_o  saturating count of back-pressured cycles [CW-1:0]
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int unsigned    DW        = 64,
    parameter logic [DW-1:0]  NOP_VALUE = {DW{1'b0}},
    parameter int unsigned    CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    occupancy_o,
    output logic [CW-1:0] stall_cnt_o
);

    // The state encoding is the entry count. The state can therefore be
    // exported directly as occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          ready_q;
    logic          valid_q;
    logic [CW-1:0] stall_q;

    logic          in_fire;
    logic          out_fire;

    // Both fire terms use only registered handshake halves from this side.
    assign in_fire  = in_valid_i & ready_q;
    assign out_fire = valid_q & out_ready_i;

    // -------------------------------------------------------------------------
    // Skid FSM
    // ready_q and valid_q are separate flops. Each one is updated in the same
    // branch that moves state_q, so they always agree with the count:
    //   ready_q == (count != 2)
    //   valid_q == (count != 0)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // Flush wins over any transition. A handshake that completes in
            // this cycle still happens at the interface, but the accepted
            // payload is dropped here.
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data_i;
                        state_q <= ST_ONE;
                        valid_q <= 1'b1;
                    end
                end

                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        // Pass-through at full rate: the old main leaves and
                        // the new payload takes its place.
                        main_q <= in_data_i;
                    end else if (in_fire) begin
                        // Downstream stalled in the cycle we accepted a
                        // payload, so park it in the skid entry.
                        skid_q  <= in_data_i;
                        state_q <= ST_FULL;
                        ready_q <= 1'b0;
                    end else if (out_fire) begin
                        main_q  <= NOP_VALUE;
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end

                ST_FULL: begin
                    // in_fire cannot happen here because ready_q is low.
                    if (out_fire) begin
                        main_q  <= skid_q;
                        skid_q  <= NOP_VALUE;
                        state_q <= ST_ONE;
                        ready_q <= 1'b1;
                    end
                end

                default: begin
                    // Encoding 3 is unreachable. Recover to a clean empty stage.
                    state_q <= ST_EMPTY;
                    main_q  <= NOP_VALUE;
                    skid_q  <= NOP_VALUE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Back-pressure stall counter.
    // It counts cycles where a payload is offered but not taken. It holds at
    // its maximum value. Flush does not clear it; only reset does.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (valid_q && !out_ready_i && (stall_q != {CW{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Directed bench for pipe_skid_stage. It uses two instances:
//   - u_dut : DW=64 with a non-zero NOP payload. It covers streaming,
//             back-pressure, pass-through and flush.
//   - u_sat : DW=8, CW=3. It covers stall-counter saturation.
//
// Inputs change 1ns after a rising edge. Outputs are sampled at that same
// point, so each sample already reflects the edge that just happened.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam logic [63:0] NOP64 = 64'h0000_0000_0000_0013;
    localparam logic [7:0]  NOP8  = 8'hA5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [63:0] in_data   = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  occ;
    logic [15:0] stall_cnt;

    pipe_skid_stage #(.DW(64), .NOP_VALUE(NOP64), .CW(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occupancy_o (occ),
        .stall_cnt_o (stall_cnt)
    );

    // ---------------- saturation instance ----------------
    logic       s_flush     = 1'b0;
    logic       s_in_valid  = 1'b0;
    logic       s_in_ready;
    logic [7:0] s_in_data   = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b0;
    logic [7:0] s_out_data;
    logic [1:0] s_occ;
    logic [2:0] s_stall;

    pipe_skid_stage #(.DW(8), .NOP_VALUE(NOP8), .CW(3)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (s_flush),
        .in_valid_i  (s_in_valid),
        .in_ready_o  (s_in_ready),
        .in_data_i   (s_in_data),
        .out_valid_o (s_out_valid),
        .out_ready_i (s_out_ready),
        .out_data_o  (s_out_data),
        .occupancy_o (s_occ),
        .stall_cnt_o (s_stall)
    );

    // ---------------- scoreboard ----------------
    int          total  = 0;
    int          passed = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // The payload on out_data must be the oldest expected entry. The caller
    // uses this only in cycles where it knows out_ready is high, so the
    // transfer happens at the next edge.
    task automatic deliver(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s observed=%0h expected=<queue empty>", tag, out_data);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_data"}, out_data, e);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data,       NOP64);
        chk("rst_occ",       64'(occ),       64'd0);
        chk("rst_stall",     64'(stall_cnt), 64'd0);
        chk("rst_sat_data",  64'(s_out_data), 64'(NOP8));
        chk("rst_sat_stall", 64'(s_stall),   64'd0);

        // Streaming 1..8 at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            step();
            chk($sformatf("stream_data_%0d", i), out_data, 64'(i));
            chk($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("stream_occ_%0d", i), 64'(occ), 64'd1);
            chk($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", 64'(out_valid), 64'd0);
        chk("stream_end_data",  out_data,       NOP64);
        chk("stream_end_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure fill: 0xA and 0xB are accepted, 0xC is held upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        step();
        chk("bp_a_occ",   64'(occ),      64'd1);
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        in_data = 64'hB;
        step();
        chk("bp_b_occ",   64'(occ),       64'd2);
        chk("bp_b_ready", 64'(in_ready),  64'd0);
        chk("bp_b_data",  out_data,       64'hA);
        chk("bp_b_stall", 64'(stall_cnt), 64'd1);
        in_data = 64'hC;
        step();
        chk("bp_c_held_occ",   64'(occ),       64'd2);
        chk("bp_c_held_data",  out_data,       64'hA);
        chk("bp_c_held_stall", 64'(stall_cnt), 64'd2);

        // Drain: A, B and C must leave in order with no gaps
        exp_q.push_back(64'hA);
        exp_q.push_back(64'hB);
        exp_q.push_back(64'hC);
        out_ready = 1'b1;
        deliver("drain_a");
        step();
        chk("drain_ready_back", 64'(in_ready), 64'd1);
        chk("drain_occ_one",    64'(occ),      64'd1);
        deliver("drain_b");            // 0xC is accepted at this same edge
        step();
        in_valid = 1'b0;
        deliver("drain_c");
        step();
        chk("drain_empty_valid", 64'(out_valid), 64'd0);
        chk("drain_empty_data",  out_data,       NOP64);
        chk("drain_stall_kept",  64'(stall_cnt), 64'd2);

        // Simultaneous in/out while holding one entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        step();
        chk("sim_main5", out_data, 64'h5);
        in_data   = 64'h6;
        out_ready = 1'b1;
        step();
        chk("sim_main6", out_data, 64'h6);
        chk("sim_occ",   64'(occ),  64'd1);
        in_valid = 1'b0;
        step();
        chk("sim_empty", 64'(occ), 64'd0);

        // Flush while FULL; 0x33 is presented during the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        step();
        in_data = 64'h22;
        step();
        chk("fl_full_occ", 64'(occ), 64'd2);
        flush   = 1'b1;
        in_data = 64'h33;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ",   64'(occ),       64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_data",  out_data,       NOP64);
        chk("fl_ready", 64'(in_ready),  64'd1);
        chk("fl_stall", 64'(stall_cnt), 64'd4);

        // Flush with an input accepted and an output taken in the same cycle
        in_valid = 1'b1;
        in_data  = 64'h44;
        step();
        chk("fl2_main", out_data, 64'h44);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 64'h55;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl2_valid", 64'(out_valid), 64'd0);
        chk("fl2_data",  out_data,       NOP64);
        step();
        chk("fl2_no55_valid", 64'(out_valid), 64'd0);
        chk("fl2_no55_occ",   64'(occ),       64'd0);

        // Stall saturation on the CW=3 instance
        s_in_valid = 1'b1;
        s_in_data  = 8'h3C;
        step();
        s_in_valid = 1'b0;
        chk("sat_hold_data", 64'(s_out_data), 64'h3C);
        chk("sat_start",     64'(s_stall),    64'd0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("sat_cnt_%0d", k), 64'(s_stall), (k > 7) ? 64'd7 : 64'(k));
        end
        chk("sat_data_stable", 64'(s_out_data), 64'h3C);
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        chk("sat_after_flush",  64'(s_stall),     64'd7);
        chk("sat_flush_valid",  64'(s_out_valid), 64'd0);
        chk("sat_flush_data",   64'(s_out_data),  64'(NOP8));
        step();
        chk("sat_idle_hold",    64'(s_stall),     64'd7);

        // Asynchronous reset clears the counters without waiting for a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sat_stall",  64'(s_stall),   64'd0);
        chk("arst_main_stall", 64'(stall_cnt), 64'd0);
        chk("arst_main_ready", 64'(in_ready),  64'd1);
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
